// File: rtl/design_exmpl_ctrl_arb.sv
// rtl/design_exmpl_ctrl_arb.sv - control unit and round-robin arbiter for the shared A/E/F datapath
//
// Grants one requester at a time to the A/E/F datapath and sequences it
// through IDLE (clear), COUNT (increment A, steer E) and DONE (report).
//
// Ports:
//   clk_i     rising-edge clock
//   rst_b_i   asynchronous active-low reset
//   req_i     per-requester level request for one datapath run
//   gnt_o     registered one-hot grant, held for the whole run
//   done_o    registered one-hot completion pulse to the granted requester
//   busy_o    high whenever the controller is not idle
//   A_i       current datapath counter value
//   clr_AF_o  datapath strobe: A <= 0, F <= 0
//   incr_A_o  datapath strobe: A <= A + 1
//   set_E_o   datapath strobe: E <= 1
//   clr_E_o   datapath strobe: E <= 0
//   set_F_o   datapath strobe: F <= 1
module design_exmpl_ctrl_arb #(
  parameter int N_REQ = 2,
  parameter int A_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [N_REQ-1:0] done_o,
  output logic             busy_o,
  input  logic [A_W-1:0]   A_i,
  output logic             clr_AF_o,
  output logic             incr_A_o,
  output logic             set_E_o,
  output logic             clr_E_o,
  output logic             set_F_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_d, done_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx, win_next;
  logic [N_REQ-1:0]   win_onehot;
  logic               clr_af, incr_a, set_e, clr_e, set_f;

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    int               idx;
    int               nxt;
    logic             found;
    logic [PTR_W-1:0] idx_l;
    idx     = 0;
    nxt     = 0;
    found   = 1'b0;
    idx_l   = '0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % N_REQ;
      idx_l = PTR_W'(idx);
      if (!found && req_i[idx_l]) begin
        found   = 1'b1;
        win_idx = idx_l;
      end
    end
    nxt        = (int'(win_idx) + 1) % N_REQ;
    win_next   = PTR_W'(nxt);
    win_onehot = N_REQ'(1) << win_idx;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_o;
    done_d  = '0;
    ptr_d   = ptr_q;
    clr_af  = 1'b0;
    incr_a  = 1'b0;
    set_e   = 1'b0;
    clr_e   = 1'b0;
    set_f   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          clr_af  = 1'b1;
          gnt_d   = win_onehot;
          ptr_d   = win_next;
          state_d = COUNT;
        end
      end
      COUNT: begin
        incr_a = 1'b1;
        set_e  = A_i[A_W-3];
        clr_e  = ~A_i[A_W-3];
        // The top two A bits both set marks the last count step.
        if (A_i[A_W-1] & A_i[A_W-2]) begin
          set_f   = 1'b1;
          done_d  = gnt_o;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes are forced low while reset is held so a held request cannot
  // clear the datapath before the controller is released.
  assign clr_AF_o = clr_af & rst_b_i;
  assign incr_A_o = incr_a & rst_b_i;
  assign set_E_o  = set_e  & rst_b_i;
  assign clr_E_o  = clr_e  & rst_b_i;
  assign set_F_o  = set_f  & rst_b_i;
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q <= IDLE;
      gnt_o   <= '0;
      done_o  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_o   <= gnt_d;
      done_o  <= done_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
